// File: rtl/seq_cla_multiplier_pkg.sv
// seq_mul_pkg: shared widths and FSM state type for the sequential CLA multiplier
package seq_mul_pkg;
    localparam int OP_W  = 6;
    localparam int RES_W = 2 * OP_W;
    localparam int SEL_W = 3;
    localparam int CNT_W = $clog2(OP_W + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/seq_cla_multiplier_if.sv
// seq_cla_multiplier_if: operand-in and product-out valid/ready handshakes
interface seq_cla_multiplier_if;
    import seq_mul_pkg::*;
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  A;
    logic [OP_W-1:0]  B;
    logic [SEL_W-1:0] SEL_in;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] CLA_result;
    logic [SEL_W-1:0] SEL;
    modport master (output in_valid, A, B, SEL_in, out_ready,
                    input  in_ready, out_valid, CLA_result, SEL);
    modport slave  (input  in_valid, A, B, SEL_in, out_ready,
                    output in_ready, out_valid, CLA_result, SEL);
endinterface

// File: rtl/seq_cla_multiplier_cla.sv
// cla_adder_12: 12-bit adder of three 4-bit lookahead groups, carry rippling between groups
module cla_adder_12 (
    input  logic [11:0] a,
    input  logic [11:0] b,
    output logic [11:0] sum,
    output logic        cout
);
    logic [3:0] carry;
    assign carry[0] = 1'b0;
    for (genvar i = 0; i < 3; i++) begin : g_grp
        logic [3:0] g, p;
        logic [4:0] c;
        assign g    = a[4*i +: 4] & b[4*i +: 4];
        assign p    = a[4*i +: 4] ^ b[4*i +: 4];
        assign c[0] = carry[i];
        assign c[1] = g[0] | (p[0] & c[0]);
        assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                    | (p[3] & p[2] & p[1] & p[0] & c[0]);
        assign sum[4*i +: 4] = p ^ c[3:0];
        assign carry[i+1]    = c[4];
    end
    assign cout = carry[3];
endmodule

// File: rtl/seq_cla_multiplier.sv
// seq_cla_multiplier: iterative shift-and-add multiplier on a 12-bit CLA; EARLY_TERM_EN ends RUN once the multiplier is exhausted
module seq_cla_multiplier
    import seq_mul_pkg::*;
(
    input logic                 clk,
    input logic                 rst_n,
    seq_cla_multiplier_if.slave io
);
    state_t           state, state_nx;
    logic [RES_W-1:0] mcand, acc, sum;
    logic [OP_W-1:0]  mplier;
    logic [SEL_W-1:0] sel_q;
    logic [CNT_W-1:0] cnt;
    logic             last, cout;

`ifdef EARLY_TERM_EN
    assign last = (mplier[OP_W-1:1] == '0) || (cnt == CNT_W'(OP_W - 1));
`else
    assign last = cnt == CNT_W'(OP_W - 1);
`endif

    cla_adder_12 u_cla (.a(acc), .b(mcand), .sum(sum), .cout(cout));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state: accept in IDLE, iterate in RUN, hold DONE until consumed
    always_comb begin
        state_nx = state == IDLE ? (io.in_valid ? RUN : IDLE)
                 : state == RUN  ? (last ? DONE : RUN)
                 : (io.out_ready ? IDLE : DONE);
    end

    // handshake outputs decoded from state
    always_comb begin
        io.in_ready  = state == IDLE;
        io.out_valid = state == DONE;
    end

    // datapath: capture on accept, one shift-and-add step per RUN edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            sel_q  <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == IDLE && io.in_valid) begin
            mcand  <= RES_W'(io.A);
            mplier <= io.B;
            sel_q  <= io.SEL_in;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            if (mplier[0]) acc <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    assign io.CLA_result = acc;
    assign io.SEL        = sel_q;

    // 63*63 fits in 12 bits, so an accumulate step can never carry out
    a_no_carry: assert property (@(posedge clk) disable iff (!rst_n)
        (state == RUN && mplier[0]) |-> !cout);
endmodule

// File: tb/tb_seq_cla_multiplier.sv
// tb_seq_cla_multiplier: scoreboard bench for seq_cla_multiplier, honours EARLY_TERM_EN
module tb_seq_cla_multiplier;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic [11:0] res;
        logic [2:0]  sel;
        int          lat;
    } exp_t;
    exp_t sb[$];

    seq_cla_multiplier_if io ();
    seq_cla_multiplier dut (.clk(clk), .rst_n(rst_n), .io(io));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [5:0] b);
`ifdef EARLY_TERM_EN
        return b == 0 ? 1 : $clog2(int'(b) + 1);
`else
        return 6;
`endif
    endfunction

    // one transaction; hold = DONE cycles with out_ready low while in_valid pulses
    task automatic do_txn(input logic [5:0] a, input logic [5:0] b, input logic [2:0] s,
                          input int hold, input bit early_rdy);
        exp_t e;
        int   n;
        n = 0;
        while (!io.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("in_ready_wait", io.in_ready, 1);
        io.A = a; io.B = b; io.SEL_in = s; io.in_valid = 1'b1; io.out_ready = early_rdy;
        e.res = 12'(a) * 12'(b);
        e.sel = s;
        e.lat = exp_lat(b);
        sb.push_back(e);
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        check("accepted", io.in_ready, 0);
        n = 0;
        while (!io.out_valid && n < 50) begin @(posedge clk); #1; n++; end
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) e = sb.pop_front();
        check("latency", n, e.lat);
        check("result", io.CLA_result, e.res);
        check("sel", io.SEL, e.sel);
        for (int i = 0; i < hold; i++) begin
            io.in_valid = 1'b1; io.A = 6'd1; io.B = 6'd1;
            @(posedge clk); #1;
            check("hold_valid", io.out_valid, 1);
            check("hold_result", io.CLA_result, e.res);
            check("hold_in_ready", io.in_ready, 0);
        end
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        io.out_ready = 1'b0;
        check("post_valid", io.out_valid, 0);
        check("post_in_ready", io.in_ready, 1);
    endtask

    initial begin
        io.in_valid = 1'b0; io.out_ready = 1'b0;
        io.A = '0; io.B = '0; io.SEL_in = '0;
        #2;
        check("rst_in_ready", io.in_ready, 1);
        check("rst_out_valid", io.out_valid, 0);
        check("rst_result", io.CLA_result, 0);
        check("rst_sel", io.SEL, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        do_txn(6'd63, 6'd63, 3'b000, 0, 1'b1);
        do_txn(6'd5, 6'd0, 3'b010, 0, 1'b0);
        do_txn(6'd12, 6'd10, 3'b001, 5, 1'b0);
        @(posedge clk); #1;
        check("pulse_ignored", io.out_valid, 0);

        io.A = 6'd20; io.B = 6'd30; io.SEL_in = 3'b101; io.in_valid = 1'b1;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_out_valid", io.out_valid, 0);
        check("abort_result", io.CLA_result, 0);
        check("abort_sel", io.SEL, 0);
        check("abort_in_ready", io.in_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        do_txn(6'd3, 6'd7, 3'b000, 0, 1'b0);

        do_txn(6'd1, 6'd1, 3'b111, 0, 1'b0);

        do_txn(6'd9, 6'd9, 3'b011, 0, 1'b0);
        @(posedge clk); #1;
        check("gap_in_ready", io.in_ready, 1);
        do_txn(6'd40, 6'd50, 3'b100, 0, 1'b0);

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
